ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Write-side controller for the single-port search RAM (A-bit address, D-bit data) that the compare/search path reads.
- Accepts a stream of D-bit words on a valid/ready handshake and writes them to consecutive RAM addresses starting at a programmable base. Alternatively clears a region to a constant fill value.
- Drives the RAM ce/we/address/data lines and the write-side address input of the read/write address mux. Reports busy, done and word count to the search sequencer.

Parameters:
- A, 8, address width
- D, 8, data width
- R, 256, RAM depth (2^A)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin an operation; sampled in IDLE only
- mode  input  1  0 = load from stream, 1 = clear with fill_val; sampled with start
- base_adr  input  A  first RAM address; sampled with start
- len  input  A+1  number of words, 0..R; sampled with start
- fill_val  input  D  constant written in clear mode; sampled with start
- in_data  input  D  stream word
- in_valid  input  1  stream word valid
- in_ready  output  1  loader accepts in_data this cycle
- gnt  input  1  RAM write grant from the read/write arbiter; 1 = write side owns the RAM
- ram_ce  output  1  RAM enable
- ram_we  output  1  RAM write enable, 1 = write
- ram_adr  output  A  RAM write address
- ram_data  output  D  RAM write data
- wr_sel  output  1  mux select request, 1 = write address path; high whenever busy
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when the last word is written
- count  output  A+1  words written in the current or last operation

Behaviour:
- Reset (async, reset_n=0): state IDLE. in_ready, ram_ce, ram_we, wr_sel, busy and done are 0. ram_adr, ram_data and count are 0. An operation in flight is abandoned; no partial write completes after reset asserts.
- States: IDLE, LOAD, CLEAR, FINISH.
- IDLE:
  - start=1 latches mode, base_adr, len and fill_val, clears count to 0 and sets busy=1 and wr_sel=1 in the next cycle.
  - Next state is LOAD (mode=0) or CLEAR (mode=1).
  - If len=0, the next state is FINISH directly and no RAM write occurs.
- start outside IDLE is ignored.
- LOAD:
  - in_ready = gnt (combinational from state and gnt).
  - A beat is accepted when in_valid & in_ready. On the following clock edge, ram_ce=ram_we=1, ram_adr=current pointer and ram_data=in_data, all registered. This gives one-cycle latency from acceptance to write strobe.
  - Pointer and count increment per accepted beat. The pointer wraps modulo R, so R-1 is followed by 0.
  - When count reaches len, go to FINISH. in_ready is 0 in the cycle after the last acceptance.
- CLEAR:
  - Each cycle with gnt=1 writes fill_val at the pointer and increments the pointer and count, with the same registered timing and wrap rules as LOAD.
  - When count reaches len, go to FINISH.
- gnt=0 in LOAD or CLEAR: no write strobe in the following cycle, pointer and count hold, in_ready=0. Resume when gnt returns.
- ram_ce/ram_we are high only in the cycle carrying a write. Otherwise they are 0, and ram_adr/ram_data hold their last values.
- FINISH:
  - done=1 for exactly one cycle, aligned with the cycle after the final write strobe (or with the FINISH cycle when len=0).
  - busy and wr_sel drop to 0 in the same cycle.
  - Next state is IDLE.
- count holds its final value until the next accepted start.
- len=R (256) with any base_adr writes every address once, wrapping through 0.

Test Plan:
- Load 4 words, base 0x10, len=4, gnt=1, stream AA,BB,CC,DD back-to-back -> writes 10:AA, 11:BB, 12:CC, 13:DD on four consecutive cycles, each one cycle after acceptance. done pulses once, count=4. Search for CC via the search block -> found flag 1, address 0x12.
- Wrap: base 0xFE, len=3, data 01,02,03 -> writes FE:01, FF:02, 00:03. done pulses, count=3.
- Clear: mode=1, base 0, len=256, fill 0x00, gnt=1 -> 256 consecutive writes, addresses 0x00..0xFF. busy high for 257 cycles, then done pulses.
- Stall: gnt drops for 3 cycles mid-load; in_valid also gapped -> in_ready=0 while gnt=0, no write strobes, no lost or duplicated words, final memory matches the stream.
- Boundary: len=0 -> no ram_we, done one cycle after start, count=0. start pulsed while busy -> ignored, parameters unchanged.
- Reset mid-load after 2 of 5 words -> all outputs 0 immediately, state IDLE. A fresh start afterward operates normally with count restarting at 0.

Source files
------------

// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader -- write-side controller for the single-port search RAM.
//
// Takes a stream of D-bit words (valid/ready) or a constant fill value and
// writes them to consecutive RAM addresses starting at a programmable base.
// The address pointer wraps modulo R.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   start, mode           operation request (IDLE only); 0 = load, 1 = clear
//   base_adr, len         first address, word count (0..R); sampled with start
//   fill_val              constant written in clear mode; sampled with start
//   in_data, in_valid     stream word and its valid
//   in_ready              loader accepts in_data this cycle
//   gnt                   write grant from the read/write arbiter
//   ram_ce, ram_we        RAM strobes, high only in a cycle carrying a write
//   ram_adr, ram_data     registered write address / data (hold when idle)
//   wr_sel                address mux select, follows busy
//   busy, done            operation in progress / one-cycle completion pulse
//   count                 words written in the current or last operation
//   dbg_state             current FSM state, for checkers and debug
//
// Handshake: a stream beat transfers on a rising edge where in_valid and
// in_ready are both high; in_valid must not depend on in_ready, and in_ready
// is combinational from the state, the word count and gnt.
// ---------------------------------------------------------------------------
module ram_loader #(
  parameter int A = 8,
  parameter int D = 8,
  parameter int R = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         mode,
  input  logic [A-1:0] base_adr,
  input  logic [A:0]   len,
  input  logic [D-1:0] fill_val,
  input  logic [D-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         gnt,
  output logic         ram_ce,
  output logic         ram_we,
  output logic [A-1:0] ram_adr,
  output logic [D-1:0] ram_data,
  output logic         wr_sel,
  output logic         busy,
  output logic         done,
  output logic [A:0]   count,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [A-1:0] LAST_ADR = A'(R - 1);

  logic [1:0]   state_q, state_d;
  logic [A-1:0] ptr_q, ptr_d;
  logic [A:0]   count_q, count_d;
  logic [A:0]   len_q, len_d;
  logic [D-1:0] fill_q, fill_d;
  logic         ce_q, ce_d;
  logic [A-1:0] adr_q, adr_d;
  logic [D-1:0] data_q, data_d;

  logic         issue;
  logic [D-1:0] wdata;
  logic         all_issued;

  // Once every word has been issued the state lingers one more cycle so the
  // final registered write strobe lands before FINISH raises done.
  assign all_issued = (count_q == len_q);

  assign in_ready = (state_q == S_LOAD) && gnt && !all_issued;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    len_d   = len_q;
    fill_d  = fill_q;
    issue   = 1'b0;
    wdata   = in_data;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          fill_d  = fill_val;
          ptr_d   = base_adr;
          count_d = '0;
          if (len == '0)
            state_d = S_FINISH;
          else if (mode)
            state_d = S_CLEAR;
          else
            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (all_issued)
          state_d = S_FINISH;
        else if (in_valid && in_ready)
          issue = 1'b1;
      end
      S_CLEAR: begin
        wdata = fill_q;
        if (all_issued)
          state_d = S_FINISH;
        else if (gnt)
          issue = 1'b1;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      ptr_d   = (ptr_q == LAST_ADR) ? '0 : ptr_q + 1'b1;
      count_d = count_q + 1'b1;
    end
  end

  // RAM side: the write issued this cycle is strobed on the next one.
  always_comb begin
    ce_d   = issue;
    adr_d  = issue ? ptr_q : adr_q;
    data_d = issue ? wdata : data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      ce_q    <= 1'b0;
      adr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      ce_q    <= ce_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
    end
  end

  assign ram_ce    = ce_q;
  assign ram_we    = ce_q;
  assign ram_adr   = adr_q;
  assign ram_data  = data_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_CLEAR);
  assign wr_sel    = busy;
  assign done      = (state_q == S_FINISH);
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_loader -- directed self-checking bench for ram_loader.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A RAM model captures every write strobe and a scoreboard (exp_q) holds the
// expected {address, data} sequence in order.
// ---------------------------------------------------------------------------
module tb_ram_loader;

  localparam int A = 8;
  localparam int D = 8;
  localparam int W = A + D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [A-1:0] base_adr = '0;
  logic [A:0]   len = '0;
  logic [D-1:0] fill_val = '0;
  logic [D-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         gnt = 1'b0;
  logic         ram_ce, ram_we;
  logic [A-1:0] ram_adr;
  logic [D-1:0] ram_data;
  logic         wr_sel, busy, done;
  logic [A:0]   count;
  logic [1:0]   dbg_state;

  ram_loader #(.A(A), .D(D), .R(256)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .base_adr(base_adr), .len(len), .fill_val(fill_val),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .gnt(gnt), .ram_ce(ram_ce), .ram_we(ram_we), .ram_adr(ram_adr),
    .ram_data(ram_data), .wr_sel(wr_sel), .busy(busy), .done(done),
    .count(count), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- RAM model + scoreboard ----------------
  logic [D-1:0] mem [256];
  logic [W-1:0] exp_q [$];

  always @(negedge clk) begin
    if (ram_ce && ram_we) begin
      mem[ram_adr] = ram_data;
      if (exp_q.size() == 0)
        check("unexpected_write", {ram_adr, ram_data}, 32'hFFFF_FFFF);
      else
        check("write", {ram_adr, ram_data}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  logic [D-1:0] stim [16];

  task automatic start_op(input logic m, input logic [A-1:0] b, input logic [A:0] n,
                          input logic [D-1:0] f);
    @(negedge clk);
    start = 1'b1; mode = m; base_adr = b; len = n; fill_val = f;
    @(negedge clk);
    start = 1'b0;
    check("start_count0", count, 0);
  endtask

  // Streams stim[0..n-1]; with stall set, gnt drops for 3 cycles and
  // in_valid has gaps. Checks in_ready and the one-cycle write latency.
  task automatic run_load(input logic [A:0] n, input bit stall);
    int idx = 0;
    int k = 0;
    logic acc;
    while (idx < int'(n) && k < 1000) begin
      gnt      = !(stall && k >= 3 && k <= 5);
      in_valid = !(stall && (k == 1 || k == 7));
      in_data  = stim[idx];
      #1;
      check("in_ready_eq_gnt", in_ready, gnt);
      acc = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      check("we_latency", ram_we, acc);
      if (acc) idx++;
      k++;
    end
    check("load_timeout", idx, n);
    in_valid = 1'b0;
    gnt = 1'b1;
    #1;
    check("ready_after_last", in_ready, 0);
    check("busy_before_finish", busy, 1);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_drop", busy, 0);
    check("wr_sel_drop", wr_sel, 0);
    check("final_count", count, n);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("count_hold", count, n);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int bc;
    bit found;
    int fa;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_ce", ram_ce, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_adr", ram_adr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    gnt = 1'b1;

    // Load 4 words at 0x10
    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD;
    exp_q.push_back(16'h10AA); exp_q.push_back(16'h11BB);
    exp_q.push_back(16'h12CC); exp_q.push_back(16'h13DD);
    start_op(1'b0, 8'h10, 9'd4, 8'h00);
    check("load_busy", busy, 1);
    check("load_wr_sel", wr_sel, 1);
    run_load(9'd4, 1'b0);
    found = 1'b0; fa = 0;
    for (int a = 0; a < 256; a++)
      if (!found && mem[a] == 8'hCC) begin found = 1'b1; fa = a; end
    check("search_found", found, 1);
    check("search_adr", fa, 32'h12);

    // Wrap through address 0
    stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03;
    exp_q.push_back(16'hFE01); exp_q.push_back(16'hFF02); exp_q.push_back(16'h0003);
    start_op(1'b0, 8'hFE, 9'd3, 8'h00);
    run_load(9'd3, 1'b0);

    // Clear all 256 words from 0, with an ignored start mid-operation
    for (int i = 0; i < 256; i++) exp_q.push_back({i[7:0], 8'h00});
    start_op(1'b1, 8'h00, 9'd256, 8'h00);
    bc = 0;
    while (busy && bc < 400) begin
      bc++;
      if (bc == 100) begin
        start = 1'b1; mode = 1'b0; base_adr = 8'h55; len = 9'd1; fill_val = 8'h77;
      end
      if (bc == 101) start = 1'b0;
      @(negedge clk);
    end
    check("clear_busy_cycles", bc, 257);
    check("clear_done", done, 1);
    check("clear_count", count, 256);
    @(negedge clk);
    check("clear_done_one_cycle", done, 0);
    check("clear_idle", dbg_state, 0);
    check("clear_count_hold", count, 256);
    check("clear_scoreboard_empty", exp_q.size(), 0);

    // Stall: gnt low for 3 cycles, gaps in in_valid
    stim[0] = 8'h31; stim[1] = 8'h32; stim[2] = 8'h33;
    stim[3] = 8'h34; stim[4] = 8'h35; stim[5] = 8'h36;
    for (int i = 0; i < 6; i++) exp_q.push_back({8'h40 + i[7:0], 8'h31 + i[7:0]});
    start_op(1'b0, 8'h40, 9'd6, 8'h00);
    run_load(9'd6, 1'b1);
    for (int i = 0; i < 6; i++) check("stall_mem", mem[8'h40 + i], 8'h31 + i);

    // len = 0: done the cycle after start, no write
    start_op(1'b0, 8'h33, 9'd0, 8'h00);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_we", ram_we, 0);
    check("len0_count", count, 0);
    @(negedge clk);
    check("len0_done_one_cycle", done, 0);
    check("len0_we_after", ram_we, 0);

    // Reset after 2 of 5 words
    exp_q.push_back(16'h8011); exp_q.push_back(16'h8122);
    start_op(1'b0, 8'h80, 9'd5, 8'h00);
    gnt = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    @(posedge clk); @(negedge clk);
    in_data = 8'h22;
    @(posedge clk); @(negedge clk);
    check("mid_count", count, 2);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_ram_ce", ram_ce, 0);
    check("mid_rst_ram_we", ram_we, 0);
    check("mid_rst_ram_adr", ram_adr, 0);
    check("mid_rst_ram_data", ram_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_sel", wr_sel, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_state", dbg_state, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_scoreboard_empty", exp_q.size(), 0);

    // Fresh load after reset
    stim[0] = 8'h5A; stim[1] = 8'hA5;
    exp_q.push_back(16'h205A); exp_q.push_back(16'h21A5);
    start_op(1'b0, 8'h20, 9'd2, 8'h00);
    run_load(9'd2, 1'b0);

    repeat (2) @(negedge clk);
    check("end_scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
